// File: rtl/if_stage_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_stage_fetch_unit
//   Instruction-fetch stage plus IF/ID pipeline register of the 5-stage core.
//   Owns the fetch PC, keeps at most one request outstanding to a
//   variable-latency instruction memory, buffers the returned word, applies
//   branch redirects resolved in ID, and hands either the buffered
//   instruction or a NOP bubble to ID under the hazard unit's
//   stall/flush/enable controls.
//
// Ports
//   clk, rst         core clock; synchronous active-high reset
//   PC_EN_IF         PC may advance or redirect this cycle
//   reg_FD_EN        IF/ID load enable
//   reg_FD_stall     IF/ID hold request
//   reg_FD_flush     IF/ID clear to bubble (highest priority)
//   Branch_ID        taken branch/jump resolved in ID
//   PC_branch_ID     redirect target
//   imem_req         one-cycle request strobe (asserted only in FETCH)
//   imem_addr        request address, equal to PC_IF
//   imem_valid       response strobe, 1..N cycles after imem_req
//   imem_rdata       response instruction word
//   PC_IF            current fetch PC
//   PC_ID            PC of the instruction held in IF/ID
//   inst_ID          instruction held in IF/ID
//   valid_ID         inst_ID is a real instruction (0 = bubble)
// ----------------------------------------------------------------------------
module if_stage_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_EN_IF,
  input  logic        reg_FD_EN,
  input  logic        reg_FD_stall,
  input  logic        reg_FD_flush,
  input  logic        Branch_ID,
  input  logic [31:0] PC_branch_ID,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] PC_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID
);

  localparam int unsigned XLEN = 32;

  // FETCH: request issued; WAIT: response pending; READY: buffer holds a
  // word not yet consumed; KILL: response pending but must be discarded.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_KILL  = 2'd3
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc_if;
  logic [XLEN-1:0]   r_pc_id;
  logic [XLEN-1:0]   r_inst_id;
  logic              r_valid_id;
  logic [XLEN-1:0]   r_buf;

  logic              w_redirect;
  logic              w_fd_hold;
  logic              w_load;
  logic [XLEN-1:0]   w_pc_plus4;

  // A redirect is only honoured when the PC is allowed to change.
  assign w_redirect = Branch_ID & PC_EN_IF;

  // IF/ID keeps its contents when stalled or not enabled.
  assign w_fd_hold  = reg_FD_stall | ~reg_FD_EN;

  // Buffer is consumed exactly once: READY, PC may advance, no redirect,
  // and IF/ID is neither flushed nor held.
  assign w_load     = (r_state == S_READY) & PC_EN_IF & ~w_redirect &
                      ~reg_FD_flush & ~w_fd_hold;

  // Wraps modulo 2^32 by construction.
  assign w_pc_plus4 = r_pc_if + XLEN'(4);

  // PC, IF/ID register, fetch buffer and fetch FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc_if    <= RESET_PC;
      r_pc_id    <= '0;
      r_inst_id  <= NOP_INST;
      r_valid_id <= 1'b0;
      r_buf      <= NOP_INST;
    end else begin
      // Fetch PC: redirect wins over sequential advance.
      if (w_redirect) begin
        r_pc_if <= PC_branch_ID;
      end else if (w_load) begin
        r_pc_if <= w_pc_plus4;
      end

      // IF/ID register: flush > hold > load > bubble.
      if (reg_FD_flush) begin
        r_inst_id  <= NOP_INST;
        r_valid_id <= 1'b0;
      end else if (w_fd_hold) begin
        r_inst_id  <= r_inst_id;
        r_valid_id <= r_valid_id;
      end else if (w_load) begin
        r_inst_id  <= r_buf;
        r_pc_id    <= r_pc_if;
        r_valid_id <= 1'b1;
      end else begin
        r_inst_id  <= NOP_INST;
        r_valid_id <= 1'b0;
      end

      // Fetch FSM; imem_valid is only observed in WAIT and KILL.
      case (r_state)
        S_FETCH: begin
          r_state <= w_redirect ? S_KILL : S_WAIT;
        end
        S_WAIT: begin
          if (w_redirect) begin
            // Response in the same cycle is stale; otherwise drain it in KILL.
            r_state <= imem_valid ? S_FETCH : S_KILL;
          end else if (imem_valid) begin
            r_buf   <= imem_rdata;
            r_state <= S_READY;
          end
        end
        S_READY: begin
          if (w_redirect || w_load) begin
            r_state <= S_FETCH;
          end
        end
        S_KILL: begin
          // A redirect here only moves the PC; the old response must still drain.
          if (imem_valid) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Request strobe is a state decode, masked so nothing is issued while
  // reset is held.
  assign imem_req  = (r_state == S_FETCH) & ~rst;
  assign imem_addr = r_pc_if;
  assign PC_IF     = r_pc_if;
  assign PC_ID     = r_pc_id;
  assign inst_ID   = r_inst_id;
  assign valid_ID  = r_valid_id;

endmodule
